i2c_target_rx: RTL

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_target_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: ACKs writes to ADDR, 4-cycle scl-to-rx_valid latency (4+FILTER_LEN with filter), no backpressure.
// Defining I2C_TARGET_FILTER_EN inserts a FILTER_LEN-sample glitch filter after the synchronizers.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR       = 7'h72,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  inout  tri1        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       rx_stop,
  output logic       busy,
  output logic       error,
  output logic [7:0] rx_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic       w_scl, w_sda;
  logic       r_scl_prev, r_sda_prev;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_byte;
  logic       w_last_bit, w_addr_hit;
  logic       w_shift_en, w_data_done, w_err;
  logic [7:0] r_rx_data, r_rx_count;
  logic       r_valid_pend, r_rx_valid, r_rx_start, r_rx_stop, r_busy, r_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int unsigned LP_CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [LP_CW-1:0] LP_CNT_LAST = LP_CW'(FILTER_LEN - 1);

  logic             r_scl_f, r_sda_f;
  logic [LP_CW-1:0] r_scl_cnt, r_sda_cnt;

  // A line follows its synchronized input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == LP_CNT_LAST) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == LP_CNT_LAST) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  localparam int unsigned LP_UNUSED_FILTER_LEN = FILTER_LEN;

  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_prev & w_sda;
  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_addr_hit = (w_byte[7:1] == ADDR);

  always_comb begin
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
    w_shift_en   = 1'b0;
    w_data_done  = 1'b0;
    w_err        = 1'b0;
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_sda_oe_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            if (w_last_bit) begin
              if (w_addr_hit && !w_byte[0]) begin
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IGNORE;
                w_err       = w_addr_hit;
              end
            end
          end
        end
        S_DATA: begin
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            if (w_last_bit) begin
              w_data_done = 1'b1;
              w_state_nxt = S_DATA_ACK;
            end
          end
        end
        // First falling edge starts the ACK low, the second one ends it.
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sda_oe     <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_rx_data    <= '0;
      r_rx_count   <= '0;
      r_valid_pend <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_start   <= 1'b0;
      r_rx_stop    <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_rx_start   <= w_start & ~w_stop;
      r_rx_stop    <= w_stop & ((r_state == S_DATA) || (r_state == S_DATA_ACK));
      r_error      <= w_err;
      r_valid_pend <= w_data_done;
      r_rx_valid   <= r_valid_pend;

      if (w_stop) begin
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_busy <= 1'b1;
      end

      // The 3-bit counter wraps to 0 after bit 8, so each byte starts clean.
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
      end

      if (w_start && !w_stop) begin
        r_rx_count <= '0;
      end else if (w_data_done) begin
        r_rx_data <= w_byte;
        if (r_rx_count != 8'hFF) begin
          r_rx_count <= r_rx_count + 8'd1;
        end
      end
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_start = r_rx_start;
  assign rx_stop  = r_rx_stop;
  assign busy     = r_busy;
  assign error    = r_error;
  assign rx_count = r_rx_count;

endmodule
